// File: rtl/rv32_pkg.sv
// Shared RV32IM definitions used by the fetch stage and the decode-stage
// control unit.
//   XLEN          : architectural register / address width
//   NOP_INSTR     : canonical NOP (ADDI x0,x0,0) used for IF/ID bubbles
//   fetch_state_t : fetch FSM state encoding
//   OPC_*         : major opcode field values (instr[6:0])
//   pc_align()    : forces an address onto a word boundary
package rv32_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_t;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry skid buffer holding a fetched {instr, pc} pair that arrived while
// decode was stalled.
//   clk, srst        : clock and synchronous active-high reset
//   load             : capture instr_in/pc_in, buffer becomes full
//   unload           : consume the entry, buffer becomes empty
//   clear            : drop the entry (flush); wins over load/unload
//   instr_in, pc_in  : entry to capture
//   instr, pc, full  : stored entry and occupancy flag
module fetch_skid_buffer
  import rv32_pkg::*;
(
  input  logic            clk,
  input  logic            srst,
  input  logic            load,
  input  logic            unload,
  input  logic            clear,
  input  logic [XLEN-1:0] instr_in,
  input  logic [XLEN-1:0] pc_in,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic            full
);

  logic [XLEN-1:0] instr_reg;
  logic [XLEN-1:0] pc_reg;
  logic            full_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      instr_reg <= NOP_INSTR;
      pc_reg    <= '0;
      full_reg  <= 1'b0;
    end else if (clear) begin
      full_reg  <= 1'b0;
    end else if (load) begin
      instr_reg <= instr_in;
      pc_reg    <= pc_in;
      full_reg  <= 1'b1;
    end else if (unload) begin
      full_reg  <= 1'b0;
    end
  end

  assign instr = instr_reg;
  assign pc    = pc_reg;
  assign full  = full_reg;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, keeps at most one request outstanding to
// instruction memory, and loads the IF/ID register consumed by decode.
//   CLK, RESET            : clock, synchronous active-high reset
//   imem_req/imem_addr    : registered fetch request and word address
//   imem_ack/imem_rdata   : memory response, sampled on the edge where ack=1
//   stall                 : decode cannot accept; IF/ID holds its contents
//   redirect/_target      : EX-stage PC change (branch/JAL/JALR)
//   if_id_instr/pc/pc_plus4/valid : IF/ID pipeline register
// A response that lands while stalled parks in the skid buffer (HOLD); a
// redirect that lands while a request is still un-acked waits out that
// request and drops its data (DISCARD).
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = rv32_pkg::NOP_INSTR
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid
);

  import rv32_pkg::*;

  fetch_state_t    state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic            req_reg, req_next;
  logic [XLEN-1:0] addr_reg, addr_next;
  logic [XLEN-1:0] if_id_instr_reg, if_id_instr_next;
  logic [XLEN-1:0] if_id_pc_reg, if_id_pc_next;
  logic [XLEN-1:0] if_id_pc_plus4_reg, if_id_pc_plus4_next;
  logic            if_id_valid_reg, if_id_valid_next;

  logic            skid_load, skid_unload, skid_clear;
  logic [XLEN-1:0] skid_instr, skid_pc;
  logic            skid_full;

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] target_aligned;

  assign pc_plus4       = pc_reg + 32'd4;
  assign target_aligned = pc_align(redirect_target);

  fetch_skid_buffer u_skid (
    .clk      (CLK),
    .srst     (RESET),
    .load     (skid_load),
    .unload   (skid_unload),
    .clear    (skid_clear),
    .instr_in (imem_rdata),
    .pc_in    (pc_reg),
    .instr    (skid_instr),
    .pc       (skid_pc),
    .full     (skid_full)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg          <= IDLE;
      pc_reg             <= RESET_PC;
      req_reg            <= 1'b0;
      addr_reg           <= RESET_PC;
      if_id_instr_reg    <= NOP_INSTR;
      if_id_pc_reg       <= '0;
      if_id_pc_plus4_reg <= '0;
      if_id_valid_reg    <= 1'b0;
    end else begin
      state_reg          <= state_next;
      pc_reg             <= pc_next;
      req_reg            <= req_next;
      addr_reg           <= addr_next;
      if_id_instr_reg    <= if_id_instr_next;
      if_id_pc_reg       <= if_id_pc_next;
      if_id_pc_plus4_reg <= if_id_pc_plus4_next;
      if_id_valid_reg    <= if_id_valid_next;
    end
  end

  always_comb begin
    state_next          = state_reg;
    pc_next             = pc_reg;
    req_next            = req_reg;
    addr_next           = addr_reg;
    if_id_instr_next    = if_id_instr_reg;
    if_id_pc_next       = if_id_pc_reg;
    if_id_pc_plus4_next = if_id_pc_plus4_reg;
    if_id_valid_next    = if_id_valid_reg;
    skid_load           = 1'b0;
    skid_unload         = 1'b0;
    skid_clear          = 1'b0;

    // When decode is not stalled it consumes IF/ID every cycle, so a cycle
    // that delivers no new instruction must present a bubble.
    case (state_reg)
      IDLE: begin
        state_next = FETCH;
        req_next   = 1'b1;
        addr_next  = pc_reg;
        if (!stall) if_id_valid_next = 1'b0;
      end

      FETCH: begin
        if (imem_ack) begin
          pc_next   = pc_plus4;
          addr_next = pc_plus4;
          if (stall) begin
            skid_load  = 1'b1;
            state_next = HOLD;
            req_next   = 1'b0;
          end else begin
            if_id_instr_next    = imem_rdata;
            if_id_pc_next       = pc_reg;
            if_id_pc_plus4_next = pc_plus4;
            if_id_valid_next    = 1'b1;
            req_next            = 1'b1;
          end
        end else if (!stall) begin
          if_id_valid_next = 1'b0;
        end
      end

      HOLD: begin
        req_next = 1'b0;
        if (!stall) begin
          if (skid_full) begin
            if_id_instr_next    = skid_instr;
            if_id_pc_next       = skid_pc;
            if_id_pc_plus4_next = skid_pc + 32'd4;
            if_id_valid_next    = 1'b1;
          end
          skid_unload = 1'b1;
          state_next  = FETCH;
          req_next    = 1'b1;
          addr_next   = pc_reg;
        end
      end

      DISCARD: begin
        if (!stall) if_id_valid_next = 1'b0;
        if (imem_ack) begin
          state_next = FETCH;
          req_next   = 1'b1;
          addr_next  = pc_reg;
        end
      end

      default: begin
        state_next = IDLE;
        req_next   = 1'b0;
      end
    endcase

    // Redirect overrides every case above. An un-acked request cannot be
    // withdrawn, so its address is held until the old response drains.
    if (redirect) begin
      if_id_valid_next = 1'b0;
      if_id_instr_next = NOP_INSTR;
      skid_clear       = 1'b1;
      skid_load        = 1'b0;
      skid_unload      = 1'b0;
      pc_next          = target_aligned;
      req_next         = 1'b1;
      if ((state_reg == FETCH || state_reg == DISCARD) && !imem_ack) begin
        state_next = DISCARD;
        addr_next  = addr_reg;
      end else begin
        state_next = FETCH;
        addr_next  = target_aligned;
      end
    end
  end

  assign imem_req       = req_reg;
  assign imem_addr      = addr_reg;
  assign if_id_instr    = if_id_instr_reg;
  assign if_id_pc       = if_id_pc_reg;
  assign if_id_pc_plus4 = if_id_pc_plus4_reg;
  assign if_id_valid    = if_id_valid_reg;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit. Inputs change and outputs are
// checked on the falling clock edge. A second instance with RESET_PC at the
// top of the address space shares the inputs and covers PC wrap-around.
module tb_instruction_fetch_unit;

  localparam logic [31:0] MASK = 32'hA5A5_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        CLK;
  logic        RESET;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;

  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic [31:0] w_pc_plus4;
  logic        w_valid;

  int total = 0;
  int bad   = 0;

  instruction_fetch_unit dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .if_id_instr     (if_id_instr),
    .if_id_pc        (if_id_pc),
    .if_id_pc_plus4  (if_id_pc_plus4),
    .if_id_valid     (if_id_valid)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .CLK             (CLK),
    .RESET           (RESET),
    .imem_req        (w_req),
    .imem_addr       (w_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .if_id_instr     (w_instr),
    .if_id_pc        (w_pc),
    .if_id_pc_plus4  (w_pc_plus4),
    .if_id_valid     (w_valid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    RESET = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
    stall = 1'b0; redirect = 1'b0; redirect_target = '0;

    // Reset values
    repeat (2) @(negedge CLK);
    chk("rst_req",    {31'd0, imem_req}, 32'd0);
    chk("rst_addr",   imem_addr, 32'h0);
    chk("rst_valid",  {31'd0, if_id_valid}, 32'd0);
    chk("rst_instr",  if_id_instr, NOP);
    chk("rst_pc",     if_id_pc, 32'h0);
    chk("rst_pc4",    if_id_pc_plus4, 32'h0);
    chk("rst_waddr",  w_addr, 32'hFFFF_FFFC);
    $display("step reset: req=%0b addr=%h valid=%0b", imem_req, imem_addr, if_id_valid);
    // A stray ack in the IDLE cycle must be ignored
    RESET = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;

    @(negedge CLK);
    chk("idle_req",   {31'd0, imem_req}, 32'd1);
    chk("idle_addr",  imem_addr, 32'h0);
    chk("idle_valid", {31'd0, if_id_valid}, 32'd0);
    $display("step first req: addr=%h", imem_addr);
    imem_ack = 1'b1; imem_rdata = 32'h0 ^ MASK;

    // Zero-wait streaming
    @(negedge CLK);
    chk("zw0_valid",  {31'd0, if_id_valid}, 32'd1);
    chk("zw0_pc",     if_id_pc, 32'h0);
    chk("zw0_instr",  if_id_instr, 32'hA5A5_0000);
    chk("zw0_pc4",    if_id_pc_plus4, 32'h4);
    chk("zw0_addr",   imem_addr, 32'h4);
    $display("step zw: if_id_pc=%h addr=%h", if_id_pc, imem_addr);
    imem_rdata = 32'h4 ^ MASK;
    for (int i = 1; i <= 2; i++) begin
      @(negedge CLK);
      chk("zw_pc",    if_id_pc, 32'(4 * i));
      chk("zw_instr", if_id_instr, 32'(4 * i) ^ MASK);
      chk("zw_pc4",   if_id_pc_plus4, 32'(4 * i + 4));
      chk("zw_addr",  imem_addr, 32'(4 * i + 4));
      $display("step zw: if_id_pc=%h addr=%h", if_id_pc, imem_addr);
      imem_rdata = 32'(4 * i + 4) ^ MASK;
    end

    // Ack delayed three cycles for the request at 0x0C
    imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("wait_addr",  imem_addr, 32'h0C);
      chk("wait_req",   {31'd0, imem_req}, 32'd1);
      chk("wait_valid", {31'd0, if_id_valid}, 32'd0);
      chk("wait_pc",    if_id_pc, 32'h08);
      $display("step wait: addr=%h valid=%0b", imem_addr, if_id_valid);
    end
    imem_ack = 1'b1; imem_rdata = 32'h0C ^ MASK;

    @(negedge CLK);
    chk("dly_pc",     if_id_pc, 32'h0C);
    chk("dly_valid",  {31'd0, if_id_valid}, 32'd1);
    chk("dly_instr",  if_id_instr, 32'hA5A5_000C);
    chk("dly_addr",   imem_addr, 32'h10);
    $display("step delayed ack: if_id_pc=%h addr=%h", if_id_pc, imem_addr);
    // Stall raised in the cycle of the ack for 0x10, held for four cycles
    imem_ack = 1'b1; imem_rdata = 32'h10 ^ MASK; stall = 1'b1;

    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("hold_req",   {31'd0, imem_req}, 32'd0);
      chk("hold_pc",    if_id_pc, 32'h0C);
      chk("hold_valid", {31'd0, if_id_valid}, 32'd1);
      $display("step hold: req=%0b if_id_pc=%h", imem_req, if_id_pc);
      imem_ack = 1'b0;
    end
    stall = 1'b0;

    @(negedge CLK);
    chk("rel_pc",     if_id_pc, 32'h10);
    chk("rel_instr",  if_id_instr, 32'hA5A5_0010);
    chk("rel_pc4",    if_id_pc_plus4, 32'h14);
    chk("rel_req",    {31'd0, imem_req}, 32'd1);
    chk("rel_addr",   imem_addr, 32'h14);
    $display("step release: if_id_pc=%h addr=%h", if_id_pc, imem_addr);
    imem_ack = 1'b1; imem_rdata = 32'h14 ^ MASK;

    @(negedge CLK);
    chk("p14_pc",     if_id_pc, 32'h14);
    chk("p14_addr",   imem_addr, 32'h18);
    $display("step: if_id_pc=%h addr=%h", if_id_pc, imem_addr);
    imem_rdata = 32'h18 ^ MASK;

    @(negedge CLK);
    chk("p18_addr",   imem_addr, 32'h1C);
    $display("step: if_id_pc=%h addr=%h", if_id_pc, imem_addr);
    imem_rdata = 32'h1C ^ MASK;

    @(negedge CLK);
    chk("p1c_pc",     if_id_pc, 32'h1C);
    chk("p1c_addr",   imem_addr, 32'h20);
    $display("step: if_id_pc=%h addr=%h", if_id_pc, imem_addr);
    // Redirect while the request for 0x20 is un-acked
    imem_ack = 1'b0; redirect = 1'b1; redirect_target = 32'h0000_0103;

    @(negedge CLK);
    chk("dis_valid",  {31'd0, if_id_valid}, 32'd0);
    chk("dis_instr",  if_id_instr, NOP);
    chk("dis_addr",   imem_addr, 32'h20);
    chk("dis_req",    {31'd0, imem_req}, 32'd1);
    $display("step discard: addr=%h valid=%0b", imem_addr, if_id_valid);
    redirect = 1'b0;

    @(negedge CLK);
    chk("dis2_addr",  imem_addr, 32'h20);
    chk("dis2_valid", {31'd0, if_id_valid}, 32'd0);
    $display("step discard wait: addr=%h", imem_addr);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;

    @(negedge CLK);
    chk("drop_valid", {31'd0, if_id_valid}, 32'd0);
    chk("drop_instr", if_id_instr, NOP);
    chk("drop_addr",  imem_addr, 32'h100);
    chk("drop_req",   {31'd0, imem_req}, 32'd1);
    $display("step dropped: addr=%h instr=%h", imem_addr, if_id_instr);
    imem_rdata = 32'h100 ^ MASK;

    @(negedge CLK);
    chk("tgt_pc",     if_id_pc, 32'h100);
    chk("tgt_instr",  if_id_instr, 32'hA5A5_0100);
    chk("tgt_valid",  {31'd0, if_id_valid}, 32'd1);
    chk("tgt_addr",   imem_addr, 32'h104);
    $display("step target: if_id_pc=%h addr=%h", if_id_pc, imem_addr);
    // Redirect, stall and ack together
    imem_rdata = 32'h104 ^ MASK; stall = 1'b1; redirect = 1'b1; redirect_target = 32'h40;

    @(negedge CLK);
    chk("all_valid",  {31'd0, if_id_valid}, 32'd0);
    chk("all_instr",  if_id_instr, NOP);
    chk("all_addr",   imem_addr, 32'h40);
    chk("all_req",    {31'd0, imem_req}, 32'd1);
    $display("step redirect+stall+ack: addr=%h valid=%0b", imem_addr, if_id_valid);
    stall = 1'b0; redirect = 1'b0; imem_rdata = 32'h40 ^ MASK;

    @(negedge CLK);
    chk("r40_pc",     if_id_pc, 32'h40);
    chk("r40_instr",  if_id_instr, 32'hA5A5_0040);
    chk("r40_valid",  {31'd0, if_id_valid}, 32'd1);
    chk("r40_addr",   imem_addr, 32'h44);
    $display("step after flush: if_id_pc=%h addr=%h", if_id_pc, imem_addr);
    imem_ack = 1'b0;

    @(negedge CLK);
    chk("mw_addr",    imem_addr, 32'h44);
    chk("mw_req",     {31'd0, imem_req}, 32'd1);
    $display("step mid-wait: addr=%h", imem_addr);
    // Reset in the middle of a wait, with an ack arriving in the same cycle
    RESET = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;

    @(negedge CLK);
    chk("rst2_req",   {31'd0, imem_req}, 32'd0);
    chk("rst2_addr",  imem_addr, 32'h0);
    chk("rst2_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rst2_instr", if_id_instr, NOP);
    chk("rst2_pc",    if_id_pc, 32'h0);
    chk("rst2_pc4",   if_id_pc_plus4, 32'h0);
    chk("rst2_wreq",  {31'd0, w_req}, 32'd0);
    chk("rst2_waddr", w_addr, 32'hFFFF_FFFC);
    $display("step reset mid-wait: req=%0b addr=%h", imem_req, imem_addr);
    RESET = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;

    @(negedge CLK);
    chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
    chk("wrap_req0",  {31'd0, w_req}, 32'd1);
    chk("wrap_valid0",{31'd0, w_valid}, 32'd0);
    chk("main_addr0", imem_addr, 32'h0);
    $display("step wrap first req: addr=%h", w_addr);
    imem_rdata = 32'h0 ^ MASK;

    @(negedge CLK);
    chk("wrap_addr1", w_addr, 32'h0);
    chk("wrap_pc",    w_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4",   w_pc_plus4, 32'h0);
    chk("wrap_valid", {31'd0, w_valid}, 32'd1);
    chk("wrap_instr", w_instr, 32'hA5A5_0000);
    $display("step wrap second req: addr=%h if_id_pc=%h", w_addr, w_pc);
    imem_ack = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
